sqrt_dr_injector: RTL
=====================

Name: sqrt_dr_injector

Overview:
- Synchronous-to-asynchronous entry stage for the dual-rail square-root datapath. It sits directly upstream of the dual-rail shift/CORDIC pipeline.
- Accepts a single-rail radicand over a valid/ready handshake and normalises it by even shifts, so the top bit-pair is non-zero.
- Drives the result as a four-phase return-to-zero dual-rail token, then sequences the spacer from the pipeline's completion-detection acknowledge.
- Reports the pair-shift count so the downstream stage can denormalise the root.

Parameters:
- SIZE, pa_AsyncCordic::RW, MSB index of the datapath; width is SIZE+1 and SIZE+1 must be even.
- SHIFT_W, $clog2((SIZE+1)/2)+1, width of the pair-shift count.
- SYNC_STAGES, 2, flops in the ack_i synchroniser (minimum 2).
- TIMEOUT, 1023, max cycles waiting on one ack_i edge before a fault is flagged.

Ports:
- clk  input  1  single clock for all state.
- arst  input  1  reset; synchronous, active-high (sampled on clk rising edge).
- in_valid  input  1  radicand valid.
- in_ready  output  1  stage can accept a radicand.
- in_data  input  SIZE+1  unsigned single-rail radicand.
- data_o  output  pa_AsyncCordic::dual_rail_t[SIZE:0]  dual-rail token to the pipeline.
- ack_i  input  1  completion-detect acknowledge from the pipeline; asynchronous to clk.
- shift_o  output  SHIFT_W  number of bit-pairs shifted left (k); held for the whole token.
- zero_o  output  1  radicand was zero; held for the whole token.
- busy_o  output  1  a token or spacer is in flight.
- err_o  output  1  sticky handshake-timeout fault.

Behaviour:
- Encoding:
  - Bit value 1 is driven as data_1=1, data_0=0.
  - Bit value 0 is driven as data_1=0, data_0=1.
  - Spacer is both rails 0 on every bit.
  - data_o only ever shows all-spacer or a complete codeword; no bit may change rails mid-token.
- All outputs are registered. The only combinational path is in_ready, decoded from state and err_o.
- Reset (arst=1 at a clk edge), from any state, including mid-token:
  - state=IDLE, data_o=spacer, shift_o=0, zero_o=0, busy_o=0, err_o=0.
  - Synchroniser flops cleared, timeout counter=0. in_ready=0 while arst is high.
- ack_i passes through SYNC_STAGES flops; ack_s is the last flop. Only ack_s is used.
- Normalisation, computed on in_data at acceptance:
  - k = number of leading all-zero bit-pairs, counting pairs from [SIZE:SIZE-1] downward.
  - Normalised value = in_data << 2k.
  - If in_data==0: k=0, zero_o=1, and the codeword is all-zero (every bit data_0=1).
- FSM:
  - IDLE:
    - in_ready=1 when err_o=0.
    - On in_valid&&in_ready: register the codeword into data_o, plus shift_o and zero_o, at that same edge. Set busy_o=1 and go to DATA.
    - Codeword is visible the cycle after the handshake (latency 1).
  - DATA:
    - Hold data_o. Wait for ack_s=1.
    - Then drive data_o=spacer at the next edge and go to SPACER.
  - SPACER:
    - Wait for ack_s=0, then go to IDLE with busy_o=0.
    - shift_o and zero_o hold until the next acceptance.
    - A new token can be accepted the cycle after IDLE is re-entered, so the minimum token period is 3+2*SYNC_STAGES cycles.
  - ack_s already 1 on entering DATA (stale ack): it is treated as an acknowledge of the new token. The pipeline contract forbids this, and the bench flags it as a protocol violation.
  - in_valid while not in IDLE is ignored; in_data is not sampled.
- Timeout:
  - A counter increments every cycle in DATA or SPACER and clears on each state change.
  - On reaching TIMEOUT: err_o=1 (sticky), data_o=spacer, state=IDLE, busy_o=0.
  - in_ready stays 0 until reset.
- ack_i glitches shorter than one clk period may be missed. This is legal, because completion detection holds ack until the spacer or data arrives.

Test Plan:
- SIZE=7, in_data=0x03 → k=3, shift_o=3, data_o encodes 0xC0 (bits 7,6 on data_1; others data_0) one cycle after the handshake.
- in_data=0x40 → shift_o=0, codeword 0x40. in_data=0x10 → shift_o=1, codeword 0x40.
- in_data=0x00 → zero_o=1, shift_o=0, all bits data_0=1. Full handshake returns to IDLE with data_o=spacer.
- Raise ack_i 5 cycles after the token, drop it 4 cycles after the spacer, SYNC_STAGES=2:
  - Spacer appears 3 cycles after the ack_i rise.
  - in_ready returns 3 cycles after the ack_i fall.
  - in_valid held high throughout is accepted exactly once per token.
- Never raise ack_i, TIMEOUT=15 → err_o=1 and data_o=spacer after 15 DATA cycles. in_ready stays 0; arst clears err_o and restores in_ready=1.
- Assert arst in DATA and in SPACER → next cycle data_o=spacer, busy_o=0, shift_o=0. A subsequent 0x03 is processed normally.

Source files
------------

// File: rtl/sqrt_dr_injector.sv
// Single-rail to four-phase dual-rail entry stage for the square-root pipeline.
// Latency 1 cycle from handshake to codeword; spacer follows synchronised ack.
// in_ready low while a token/spacer is in flight, after a timeout fault, or in reset.
package pa_AsyncCordic;
    localparam int RW = 7;

    typedef struct packed {
        logic data_1;
        logic data_0;
    } dual_rail_t;
endpackage

module sqrt_dr_injector #(
    parameter int SIZE        = pa_AsyncCordic::RW,
    parameter int SHIFT_W     = $clog2((SIZE + 1) / 2) + 1,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic                                clk,
    input  logic                                arst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [SIZE:0]                       in_data,
    output pa_AsyncCordic::dual_rail_t [SIZE:0] data_o,
    input  logic                                ack_i,
    output logic [SHIFT_W-1:0]                  shift_o,
    output logic                                zero_o,
    output logic                                busy_o,
    output logic                                err_o
);
    localparam int NPAIRS = (SIZE + 1) / 2;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, SPACER} state_t;

    state_t                              state;
    logic [SYNC_STAGES-1:0]              ack_sync;
    logic                                ack_s;
    logic [TMO_W-1:0]                    tmo_cnt;
    logic                                tmo_hit;

    logic [SHIFT_W-1:0]                  norm_k;
    logic                                norm_zero;
    logic [SIZE:0]                       norm_val;
    pa_AsyncCordic::dual_rail_t [SIZE:0] norm_cw;

    assign ack_s    = ack_sync[SYNC_STAGES-1];
    assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign in_ready = (state == IDLE) && !err_o && !arst;

    // Leading zero bit-pairs; a zero radicand is reported via zero_o with k=0.
    always_comb begin
        logic found;
        found     = 1'b0;
        norm_k    = '0;
        norm_zero = (in_data == '0);
        for (int i = 0; i < NPAIRS; i++) begin
            if (!found) begin
                if (in_data[SIZE-2*i -: 2] != 2'b00) found = 1'b1;
                else                                 norm_k = norm_k + SHIFT_W'(1);
            end
        end
        if (norm_zero) norm_k = '0;
        norm_val = in_data << {norm_k, 1'b0};
        for (int i = 0; i <= SIZE; i++) begin
            norm_cw[i].data_1 = norm_val[i];
            norm_cw[i].data_0 = ~norm_val[i];
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state    <= IDLE;
            ack_sync <= '0;
            tmo_cnt  <= '0;
            data_o   <= '0;
            shift_o  <= '0;
            zero_o   <= 1'b0;
            busy_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_i};
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        data_o  <= norm_cw;
                        shift_o <= norm_k;
                        zero_o  <= norm_zero;
                        busy_o  <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (ack_s) begin
                        data_o  <= '0;
                        tmo_cnt <= '0;
                        state   <= SPACER;
                    end else if (tmo_hit) begin
                        err_o   <= 1'b1;
                        data_o  <= '0;
                        busy_o  <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                SPACER: begin
                    if (!ack_s) begin
                        busy_o  <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else if (tmo_hit) begin
                        // Pipeline never released ack: park at spacer and latch the fault.
                        err_o   <= 1'b1;
                        data_o  <= '0;
                        busy_o  <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: begin
                    data_o <= '0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
